single_clock_fifo: RTL and testbench



---
 rtl/single_clock_fifo_pkg.sv | 13 +
 rtl/single_clock_fifo_ptr_ctrl.sv | 26 ++
 rtl/single_clock_fifo.sv | 71 +++++++
 tb/tb_single_clock_fifo.sv | 126 ++++++++++++
 4 files changed

// File: rtl/single_clock_fifo_pkg.sv
// Shared sizing constants for the single-clock FIFO and its pointer controllers.
package single_clock_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  localparam int unsigned FIFO_DEPTH = fifo_depth(DEF_ADDR_WIDTH);

endpackage

// File: rtl/single_clock_fifo_ptr_ctrl.sv
// Binary FIFO pointer with a wrap bit: advances on enable unless the blocking flag is set.
module fifo_ptr_ctrl
  import single_clock_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_block,
  output logic [ADDR_WIDTH:0] o_ptr
);

  logic [ADDR_WIDTH:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && !i_block) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/single_clock_fifo.sv
// 16 x 8-bit single-clock FIFO with registered read data and full/empty flags.
module single_clock_fifo
  import single_clock_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH:0]   w_wptr;
  logic [ADDR_WIDTH:0]   w_rptr;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_data_out;

  // Flags come from registered pointers, so both sides see pre-edge status.
  assign empty     = (w_wptr == w_rptr);
  assign full      = (w_wptr[ADDR_WIDTH] != w_rptr[ADDR_WIDTH]) &&
                     (w_wptr[ADDR_WIDTH-1:0] == w_rptr[ADDR_WIDTH-1:0]);
  assign w_wr_fire = w_en && !full && !rst;
  assign w_rd_fire = r_en && !empty;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_en),
    .i_block (full),
    .o_ptr   (w_wptr)
  );

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (r_en),
    .i_block (empty),
    .o_ptr   (w_rptr)
  );

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[w_wptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_rd_fire) begin
      r_data_out <= r_mem[w_rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_single_clock_fifo.sv
// Directed scoreboard bench for single_clock_fifo.
module tb_single_clock_fifo;
  import single_clock_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  logic [7:0] q[$];
  logic [7:0] exp_dout = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  single_clock_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/data_out"}, {24'd0, data_out}, {24'd0, exp_dout});
    check({tag, "/empty"}, {31'd0, empty}, {31'd0, (q.size() == 0)});
    check({tag, "/full"}, {31'd0, full}, {31'd0, (q.size() == FIFO_DEPTH)});
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
    bit wr_ok;
    bit rd_ok;
    w_en    = w;
    r_en    = r;
    data_in = d;
    wr_ok   = w && (q.size() < FIFO_DEPTH);
    rd_ok   = r && (q.size() != 0);
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    w_en = 1'b0;
    r_en = 1'b0;
    check_all(tag);
  endtask

  task automatic reset_cycle(input string tag, input logic w, input logic r);
    rst     = 1'b1;
    w_en    = w;
    r_en    = r;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    q.delete();
    exp_dout = 8'h00;
    rst  = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // Reset held two cycles with both requests asserted.
    reset_cycle("reset0", 1'b1, 1'b1);
    rst = 1'b1;
    reset_cycle("reset1", 1'b1, 1'b1);

    // Fill 0x01..0x10, then an ignored write while full.
    for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
    cycle("overfill", 1'b1, 1'b0, 8'hFF);

    // Drain, then an ignored read while empty.
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
    cycle("underflow", 1'b0, 1'b1, 8'h00);
    check("underflow/hold10", {24'd0, data_out}, 32'h10);

    // Move pointers near the wrap point so the concurrent phase crosses it.
    for (int i = 0; i < 12; i++) cycle("adv_w", 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 12; i++) cycle("adv_r", 1'b0, 1'b1, 8'h00);

    // Four stored, then eight concurrent write/read cycles.
    for (int i = 0; i < 4; i++) cycle("pre4", 1'b1, 1'b0, 8'(8'h21 + i));
    for (int i = 0; i < 8; i++) cycle("simul", 1'b1, 1'b1, 8'(8'h31 + i));
    check("simul/occupancy", q.size(), 32'd4);
    for (int i = 0; i < 4; i++) cycle("post_drain", 1'b0, 1'b1, 8'h00);

    // Empty with both requests: write accepted, data_out unchanged.
    cycle("empty_wr", 1'b1, 1'b1, 8'h5A);
    check("empty_wr/hold", {24'd0, data_out}, 32'h38);

    // Full with both requests: read accepted, write dropped.
    for (int i = 0; i < 15; i++) cycle("refill", 1'b1, 1'b0, 8'(8'h60 + i));
    cycle("full_rw", 1'b1, 1'b1, 8'hEE);
    check("full_rw/data", {24'd0, data_out}, 32'h5A);
    for (int i = 0; i < 15; i++) cycle("full_drain", 1'b0, 1'b1, 8'h00);

    // Mid-operation reset discards stored words.
    for (int i = 0; i < 7; i++) cycle("pre_rst", 1'b1, 1'b0, 8'(8'h80 + i));
    reset_cycle("mid_rst", 1'b0, 1'b0);
    cycle("post_rst_w", 1'b1, 1'b0, 8'hA5);
    cycle("post_rst_r", 1'b0, 1'b1, 8'h00);
    check("post_rst/a5", {24'd0, data_out}, 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
